// File: rtl/fitness_pkg.sv
// Shared definitions for the fitness scheduler: default sizes and FSM states.
package fitness_pkg;

  localparam int POP_SIZE_DEF = 50;
  localparam int GENE_W_DEF   = 150;
  localparam int DIST_W_DEF   = 12;
  localparam int IDX_W_DEF    = $clog2(POP_SIZE_DEF);
  localparam int TIMEOUT_DEF  = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/fitness_sched_if.sv
// Handshake bundle between the scheduler and the shared distance engine.
interface fitness_sched_if
  import fitness_pkg::*;
#(
  parameter int GENE_W = GENE_W_DEF,
  parameter int DIST_W = DIST_W_DEF
);
  logic              eng_start;
  logic [GENE_W-1:0] eng_in;
  logic              eng_done;
  logic [DIST_W-1:0] eng_distance;

  modport master (
    output eng_start,
    output eng_in,
    input  eng_done,
    input  eng_distance
  );

  modport slave (
    input  eng_start,
    input  eng_in,
    output eng_done,
    output eng_distance
  );
endinterface

// File: rtl/fitness_best_tracker.sv
// Running minimum of captured distances; on equal values the earlier
// (lower) index is kept because only a strictly smaller distance replaces it.
module fitness_best_tracker
  import fitness_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DIST_W = DIST_W_DEF
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              capture,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DIST_W-1:0] distance,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DIST_W-1:0] best_dist
);

  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [DIST_W-1:0] best_dist_q, best_dist_d;

  // Next best: reset to "nothing seen" on clear, else keep the strict minimum.
  always_comb begin
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    if (clear) begin
      best_idx_d  = '0;
      best_dist_d = '1;
    end else if (capture && (distance < best_dist_q)) begin
      best_idx_d  = idx;
      best_dist_d = distance;
    end else begin
      best_idx_d  = best_idx_q;
      best_dist_d = best_dist_q;
    end
  end

  // Best-so-far registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_idx_q  <= '0;
      best_dist_q <= '1;
    end else begin
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
    end
  end

  assign best_idx  = best_idx_q;
  assign best_dist = best_dist_q;

endmodule

// File: rtl/fitness_sched.sv
// Fitness scheduler: walks the population through one shared distance
// engine, index 0 first, storing each result and tracking the minimum.
// Optional feature macro FITNESS_TIMEOUT_EN adds a per-individual engine
// wait limit (TIMEOUT cycles) with a sticky timeout_err flag.
module fitness_sched
  import fitness_pkg::*;
#(
  parameter int POP_SIZE = POP_SIZE_DEF,
  parameter int GENE_W   = GENE_W_DEF,
  parameter int DIST_W   = DIST_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [POP_SIZE*GENE_W-1:0]   pop,
  output logic                         busy,
  output logic                         done,
  output logic [POP_SIZE*DIST_W-1:0]   distances,
  output logic [$clog2(POP_SIZE)-1:0]  best_idx,
  output logic [DIST_W-1:0]            best_dist,
  output logic                         timeout_err,
  fitness_sched_if.master              eng
);

  localparam int IDX_W = $clog2(POP_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       eng_start_q, eng_start_d;
  logic [GENE_W-1:0]          eng_in_q, eng_in_d;
  logic [POP_SIZE*DIST_W-1:0] distances_q, distances_d;
  // High only during the first WAIT cycle: an eng_done still asserted from
  // the previous transaction must not be mistaken for the new result.
  logic                       first_q, first_d;
  logic [IDX_W-1:0]           nxt_idx_s;
  logic                       clear_s, capture_s, advance_s;

`ifdef FITNESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  assign nxt_idx_s = (idx_q == LAST_IDX) ? '0 : (idx_q + 1'b1);

  // Next-state, slot write and output computation for the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    eng_start_d = 1'b0;
    eng_in_d    = eng_in_q;
    distances_d = distances_q;
    first_d     = 1'b0;
    clear_s     = 1'b0;
    capture_s   = 1'b0;
    advance_s   = 1'b0;
`ifdef FITNESS_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d     = ST_LAUNCH;
          idx_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          eng_start_d = 1'b1;
          eng_in_d    = pop[0 +: GENE_W];
          clear_s     = 1'b1;
`ifdef FITNESS_TIMEOUT_EN
          timeout_err_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        first_d = 1'b1;
`ifdef FITNESS_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (!first_q && eng.eng_done) begin
          distances_d[int'(idx_q)*DIST_W +: DIST_W] = eng.eng_distance;
          capture_s = 1'b1;
          advance_s = 1'b1;
`ifdef FITNESS_TIMEOUT_EN
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          distances_d[int'(idx_q)*DIST_W +: DIST_W] = '1;
          timeout_err_d = 1'b1;
          advance_s     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance_s) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_FINISH;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d     = ST_LAUNCH;
        idx_d       = nxt_idx_s;
        eng_start_d = 1'b1;
        eng_in_d    = pop[int'(nxt_idx_s)*GENE_W +: GENE_W];
      end
    end else begin
      idx_d = idx_d;
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_in_q    <= '0;
      distances_q <= '0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eng_start_q <= eng_start_d;
      eng_in_q    <= eng_in_d;
      distances_q <= distances_d;
      first_q     <= first_d;
    end
  end

`ifdef FITNESS_TIMEOUT_EN
  // Engine wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  fitness_best_tracker #(
    .IDX_W  (IDX_W),
    .DIST_W (DIST_W)
  ) u_best (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_s),
    .capture   (capture_s),
    .idx       (idx_q),
    .distance  (eng.eng_distance),
    .best_idx  (best_idx),
    .best_dist (best_dist)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign distances     = distances_q;
  assign eng.eng_start = eng_start_q;
  assign eng.eng_in    = eng_in_q;

endmodule

// File: tb/tb_fitness_sched.sv
// Directed bench for fitness_sched with a latency-3 engine model.
module tb_fitness_sched;
  localparam int POP = 50;
  localparam int GW  = 150;
  localparam int DW  = 12;
  localparam int IW  = $clog2(POP);
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [POP*GW-1:0] pop;
  logic              busy, done, timeout_err;
  logic [POP*DW-1:0] distances;
  logic [IW-1:0]     best_idx;
  logic [DW-1:0]     best_dist;

  fitness_sched_if #(.GENE_W(GW), .DIST_W(DW)) eng_if ();

  fitness_sched #(
    .POP_SIZE (POP),
    .GENE_W   (GW),
    .DIST_W   (DW),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pop         (pop),
    .busy        (busy),
    .done        (done),
    .distances   (distances),
    .best_idx    (best_idx),
    .best_dist   (best_dist),
    .timeout_err (timeout_err),
    .eng         (eng_if)
  );

  always #5 clk = ~clk;

  int mode = 0;
  int silent = -1;
  bit stale_hold = 1'b0;
  int cnt = 0;
  int eng_k = 0;
  int n_launch = 0;
  int n_checks = 0;
  int n_pass = 0;
  int cyc;
  int base;

  function automatic logic [DW-1:0] dist_of(int k);
    case (mode)
      0:       return DW'(100 - k);
      1:       return DW'(7);
      default: return DW'(300 - k);
    endcase
  endfunction

  function automatic logic [DW-1:0] slot(int k);
    return distances[k*DW +: DW];
  endfunction

  // Engine model: result LAT cycles after eng_start; optionally leaves the
  // old eng_done up for one extra cycle, or stays silent for one index.
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_if.eng_done     <= 1'b0;
      eng_if.eng_distance <= '0;
      cnt                 <= 0;
    end else if (eng_if.eng_start) begin
      n_launch <= n_launch + 1;
      eng_k    <= int'(eng_if.eng_in[5:0]);
      if (!stale_hold) eng_if.eng_done <= 1'b0;
      cnt <= (int'(eng_if.eng_in[5:0]) == silent) ? 0 : LAT;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        eng_if.eng_done     <= 1'b1;
        eng_if.eng_distance <= dist_of(eng_k);
      end else begin
        eng_if.eng_done <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      tick();
      start = 1'b0;
      cycles++;
    end while (!done && cycles < 3000);
    if (!done) chk("done_wait_expired", 64'(done), 64'd1);
  endtask

  task automatic wait_launch(input int b, input int n);
    int g = 0;
    while ((n_launch - b) < n && g < 3000) begin
      tick();
      g++;
    end
    if ((n_launch - b) < n) chk("launch_wait_expired", 64'(n_launch - b), 64'(n));
  endtask

  initial begin
    for (int k = 0; k < POP; k++) pop[k*GW +: GW] = GW'(k);
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_eng_start", 64'(eng_if.eng_start), 64'd0);
    chk("rst_best_dist", 64'(best_dist), 64'hFFF);
    chk("rst_best_idx", 64'(best_idx), 64'd0);
    chk("rst_dist_zero", 64'(|distances), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Run A: distances 100-k
    mode = 0; base = n_launch; start = 1'b1;
    wait_done(cyc);
    chk("A_cycles", 64'(cyc), 64'd251);
    chk("A_best_idx", 64'(best_idx), 64'd49);
    chk("A_best_dist", 64'(best_dist), 64'd51);
    chk("A_busy", 64'(busy), 64'd0);
    chk("A_slot0", 64'(slot(0)), 64'd100);
    chk("A_slot25", 64'(slot(25)), 64'd75);
    chk("A_slot49", 64'(slot(49)), 64'd51);
    chk("A_launches", 64'(n_launch - base), 64'd50);
    chk("A_timeout", 64'(timeout_err), 64'd0);

    // Run B: all ties
    mode = 1; start = 1'b1;
    wait_done(cyc);
    chk("B_best_idx", 64'(best_idx), 64'd0);
    chk("B_best_dist", 64'(best_dist), 64'd7);
    chk("B_slot30", 64'(slot(30)), 64'd7);

    // Run C: stale eng_done held into the first WAIT cycle
    mode = 2; stale_hold = 1'b1; start = 1'b1;
    wait_done(cyc);
    stale_hold = 1'b0;
    chk("C_cycles", 64'(cyc), 64'd251);
    chk("C_slot0", 64'(slot(0)), 64'd300);
    chk("C_slot1", 64'(slot(1)), 64'd299);
    chk("C_best_dist", 64'(best_dist), 64'd251);
    chk("C_best_idx", 64'(best_idx), 64'd49);

    // Run D: start pulsed during idx=10 WAIT is ignored
    mode = 0; base = n_launch; start = 1'b1;
    tick(); start = 1'b0;
    wait_launch(base, 11);
    chk("D_slot30_retained", 64'(slot(30)), 64'd270);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("D_busy_mid", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("D_launches", 64'(n_launch - base), 64'd50);
    chk("D_slot30", 64'(slot(30)), 64'd70);
    chk("D_best_dist", 64'(best_dist), 64'd51);

    // Reset during idx=20 WAIT
    mode = 1; base = n_launch; start = 1'b1;
    tick(); start = 1'b0;
    wait_launch(base, 21);
    tick();
    rst_n = 1'b0;
    #1;
    chk("R_busy", 64'(busy), 64'd0);
    chk("R_done", 64'(done), 64'd0);
    chk("R_eng_start", 64'(eng_if.eng_start), 64'd0);
    chk("R_eng_in", 64'(|eng_if.eng_in), 64'd0);
    chk("R_dist_zero", 64'(|distances), 64'd0);
    chk("R_best_dist", 64'(best_dist), 64'hFFF);
    chk("R_best_idx", 64'(best_idx), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    base = n_launch; start = 1'b1;
    wait_done(cyc);
    chk("R_cycles", 64'(cyc), 64'd251);
    chk("R_launches", 64'(n_launch - base), 64'd50);
    chk("R_slot0", 64'(slot(0)), 64'd7);
    chk("R_best_dist_run", 64'(best_dist), 64'd7);

`ifdef FITNESS_TIMEOUT_EN
    // Engine silent for idx=5
    mode = 0; silent = 5; start = 1'b1;
    wait_done(cyc);
    silent = -1;
    chk("T_slot5", 64'(slot(5)), 64'hFFF);
    chk("T_slot6", 64'(slot(6)), 64'd94);
    chk("T_flag", 64'(timeout_err), 64'd1);
    chk("T_best_idx", 64'(best_idx), 64'd49);
    chk("T_best_dist", 64'(best_dist), 64'd51);
    start = 1'b1;
    wait_done(cyc);
    chk("T_flag_cleared", 64'(timeout_err), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fitness_sched.md
FITNESS_SCHED -- requirements
Module: fitness_sched

Interface
REQ-001 Parameter POP_SIZE, default 50, number of individuals per population.
REQ-002 Parameter GENE_W, default 150, bits per individual.
REQ-003 Parameter DIST_W, default 12, bits per distance result.
REQ-004 Parameter TIMEOUT, default 4096, max engine wait cycles per individual (used only under FITNESS_TIMEOUT_EN).
REQ-005 clk  input  1  single clock; all state rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  request to evaluate the whole population.
REQ-008 pop  input  POP_SIZE*GENE_W  population; individual k = pop[k*GENE_W +: GENE_W]; held stable by source while busy=1.
REQ-009 busy  output  1  evaluation in progress.
REQ-010 done  output  1  level; results valid, held until next accepted start.
REQ-011 distances  output  POP_SIZE*DIST_W  slot k = distances[k*DIST_W +: DIST_W].
REQ-012 best_idx  output  IDX_W=$clog2(POP_SIZE)  index of minimum distance.
REQ-013 best_dist  output  DIST_W  minimum distance.
REQ-014 eng_start  output  1  one-cycle launch pulse to the shared distance engine.
REQ-015 eng_in  output  GENE_W  individual presented to the engine.
REQ-016 eng_done  input  1  engine result valid (level, cleared by engine on eng_start).
REQ-017 eng_distance  input  DIST_W  engine result.
REQ-018 timeout_err  output  1  sticky engine-timeout flag.

Function
REQ-019 FSM states IDLE, LAUNCH, WAIT, FINISH; one shared engine serves all POP_SIZE individuals sequentially, index 0 first.
REQ-020 start sampled only in IDLE or FINISH; accepted start -> LAUNCH next cycle, idx=0, done=0, busy=1, best_dist=all-ones, best_idx=0, timeout_err=0; start while busy ignored.
REQ-021 LAUNCH: eng_start=1 for exactly one cycle, eng_in=slice idx (held through WAIT) -> WAIT.
REQ-022 WAIT: eng_done ignored in first WAIT cycle (stale-done guard); from second cycle, eng_done=1 captures eng_distance into slot idx.
REQ-023 On capture, eng_distance < best_dist (strict) updates best_dist/best_idx; ties keep lower index.
REQ-024 On capture with idx<POP_SIZE-1: idx+1, -> LAUNCH; with idx=POP_SIZE-1: -> FINISH, done=1, busy=0 next cycle.
REQ-025 Per-individual cost = 2 + engine latency cycles; engine latency L>=1 gives total POP_SIZE*(L+2)+1 cycles start-to-done.
REQ-026 Slots not yet evaluated in a run retain previous-run values until overwritten.
REQ-027 eng_start=0 in all states except LAUNCH.

Reset
REQ-028 rst_n=0 at any time, including mid-WAIT, forces IDLE immediately: busy=0, done=0, eng_start=0, eng_in=0, distances=0, best_dist=all-ones, best_idx=0, timeout_err=0, idx=0.
REQ-029 First start after reset release behaves as REQ-020; no engine transaction is resumed.

Configuration
REQ-030 Macro FITNESS_TIMEOUT_EN defined: WAIT cycle counter; reaching TIMEOUT without eng_done stores all-ones in slot idx, sets timeout_err (sticky until next accepted start), proceeds as REQ-024, no best update.
REQ-031 Macro undefined: no counter, WAIT indefinitely, timeout_err tied 0.

Structure
REQ-032 Package fitness_pkg holds POP_SIZE, GENE_W, DIST_W, IDX_W defaults and the FSM state enum.
REQ-033 Sub-module fitness_best_tracker (clear, capture, idx, distance -> best_idx, best_dist) implements REQ-023.

Verification
REQ-034 Engine model L=3, distances 100-k for k=0..49 -> done after 50*5+1=251 cycles, best_idx=49, best_dist=51, busy low.
REQ-035 All distances 7 -> best_idx=0, best_dist=7 (tie rule).
REQ-036 start pulsed during idx=10 WAIT -> ignored, run completes normally, exactly 50 eng_start pulses.
REQ-037 rst_n low during idx=20 WAIT -> all outputs at reset values next cycle; new start re-evaluates from idx=0.
REQ-038 FITNESS_TIMEOUT_EN, TIMEOUT=16, engine silent for idx=5 -> slot 5=0xFFF, timeout_err=1, run completes, best excludes slot 5.
REQ-039 eng_done held 1 from previous run at start -> first-WAIT-cycle value not captured; slot 0 = new engine result.
